alu_seq: RTL and testbench

Parametrised, handshaked multi-cycle ALU for the Mimas V2 datapath. Operands and an opcode are accepted through a valid/ready handshake, and the block produces a registered result and status flags. Logic ops finish in one cycle. Multiply and divide are iterative shift-add / restoring-subtract engines. The block replaces the fixed 8-bit combinational ALU wherever a wider result, a flagged result or flow control is needed.

---
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked multi-cycle ALU with a shift-add multiplier and an
//            optional restoring divider (built only when ALU_DIV_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_op,
  input  logic [WIDTH-1:0]     i_A,
  input  logic [WIDTH-1:0]     i_B,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_zero,
  output logic                 o_carry,
  output logic                 o_err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ABS = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   quick_res;
  logic                 quick_carry;
  logic                 quick_err;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [2*WIDTH-1:0]   step_nxt;
  logic                 accept;
  logic                 start_calc;

  assign accept = i_valid & o_ready;
  assign sum    = {1'b0, i_A} + {1'b0, i_B};

  // prod holds {partial product, remaining multiplier bits} for MUL and
  // {partial remainder, dividend/quotient bits} for DIV.
  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_nxt = {mul_sum, prod[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic                 is_div;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   div_nxt;

  assign shifted    = prod[2*WIDTH-1:WIDTH-1];
  assign ge         = shifted >= {1'b0, opnd};
  assign diff       = shifted[WIDTH-1:0] - opnd;
  assign div_nxt    = {(ge ? diff : shifted[WIDTH-1:0]), prod[WIDTH-2:0], ge};
  assign step_nxt   = is_div ? div_nxt : mul_nxt;
  assign start_calc = (i_op == OP_MUL) || ((i_op == OP_DIV) && (i_B != '0));
`else
  assign step_nxt   = mul_nxt;
  assign start_calc = (i_op == OP_MUL);
`endif

  always_comb begin
    quick_res   = '0;
    quick_carry = 1'b0;
    quick_err   = 1'b0;
    case (i_op)
      OP_ADD: begin
        quick_res   = {{(WIDTH-1){1'b0}}, sum};
        quick_carry = sum[WIDTH];
      end
      OP_ABS: begin
        quick_res[WIDTH-1:0] = (i_A >= i_B) ? (i_A - i_B) : (i_B - i_A);
        quick_carry          = (i_A < i_B);
      end
      OP_AND: quick_res[WIDTH-1:0] = i_A & i_B;
      OP_OR:  quick_res[WIDTH-1:0] = i_A | i_B;
      OP_XOR: quick_res[WIDTH-1:0] = i_A ^ i_B;
      OP_CMP: quick_res[1:0] = {(i_A > i_B), (i_A == i_B)};
      OP_DIV: begin
`ifdef ALU_DIV_EN
        quick_res = {i_A, {WIDTH{1'b1}}};
`else
        quick_res = '1;
`endif
        quick_err = 1'b1;
      end
      default: quick_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_calc ? CALC : DONE;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      opnd     <= '0;
      prod     <= '0;
      o_ready  <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b0;
      o_carry  <= 1'b0;
      o_err    <= 1'b0;
`ifdef ALU_DIV_EN
      is_div   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_ready <= 1'b0;
            cnt     <= CW'(WIDTH - 1);
`ifdef ALU_DIV_EN
            is_div  <= (i_op == OP_DIV);
            opnd    <= (i_op == OP_DIV) ? i_B : i_A;
            prod    <= {{WIDTH{1'b0}}, ((i_op == OP_DIV) ? i_A : i_B)};
`else
            opnd    <= i_A;
            prod    <= {{WIDTH{1'b0}}, i_B};
`endif
            if (!start_calc) begin
              o_valid  <= 1'b1;
              o_result <= quick_res;
              o_zero   <= (quick_res == '0);
              o_carry  <= quick_carry;
              o_err    <= quick_err;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        CALC: begin
          cnt  <= cnt - 1'b1;
          prod <= step_nxt;
          if (cnt == '0) begin
            o_valid  <= 1'b1;
            o_result <= step_nxt;
            o_zero   <= (step_nxt == '0);
            o_carry  <= 1'b0;
            o_err    <= 1'b0;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: o_ready <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// Testbench for alu_seq (WIDTH=8): directed vectors with literal expectations
// plus a queue-based reference model checked on every cycle o_valid is high.
module tb_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic [2:0]     i_op = '0;
  logic [W-1:0]   i_A = '0;
  logic [W-1:0]   i_B = '0;
  logic           o_valid;
  logic           i_ready = 1'b0;
  logic [2*W-1:0] o_result;
  logic           o_zero, o_carry, o_err;

  alu_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_A(i_A), .i_B(i_B), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_zero(o_zero), .o_carry(o_carry), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    logic        z, c, e;
    int          lat;
    int          due;
  } exp_t;

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t        r;
    int unsigned ai = a;
    int unsigned bi = b;
    int unsigned v  = 0;
    r.c = 1'b0; r.e = 1'b0; r.lat = 1; r.due = 0;
    case (op)
      3'd0: begin v = ai + bi; r.c = (v > 255); end
      3'd1: begin v = (ai > bi) ? ai - bi : bi - ai; r.c = (ai < bi); end
      3'd2: begin v = ai * bi; r.lat = W + 1; end
      3'd3: v = ai & bi;
      3'd4: v = ai | bi;
      3'd5: v = ai ^ bi;
      3'd6: v = ((ai == bi) ? 1 : 0) + ((ai > bi) ? 2 : 0);
      default: begin
`ifdef ALU_DIV_EN
        if (bi == 0) begin v = ai * 256 + 255; r.e = 1'b1; end
        else begin v = (ai % bi) * 256 + (ai / bi); r.lat = W + 1; end
`else
        v = 16'hFFFF; r.e = 1'b1;
`endif
      end
    endcase
    r.res = v[15:0];
    r.z   = (v == 0);
    return r;
  endfunction

  // Scoreboard: accepted ops queue up; each must emerge once, on time, stable.
  exp_t q[$];
  exp_t e;
  bit   seen = 0, consumed = 0, consumed_prev = 0;
  bit   r1 = 1, r2 = 1;

  always @(negedge clk) begin
    consumed = 0;
    if (!i_rst_n) begin
      q.delete();
      seen = 0;
    end else begin
      if (!r1) begin
        chk("reset_ready", o_ready, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_result", o_result, 0);
        chk("reset_flags", {o_zero, o_carry, o_err}, 0);
      end else if (!r2) begin
        chk("ready_after_reset", o_ready, 1);
      end
      if (consumed_prev) chk("ready_after_take", o_ready, 1);
      if (q.size() > 0) chk("busy_not_ready", o_ready, 0);
      if (q.size() == 0) chk("no_spurious_valid", o_valid, 0);
      else if (seen) chk("valid_held", o_valid, 1);
      if (o_valid && q.size() > 0) begin
        if (!seen) begin
          chk("latency", cyc, q[0].due);
          seen = 1;
        end
        chk("result", o_result, q[0].res);
        chk("zero", o_zero, q[0].z);
        chk("carry", o_carry, q[0].c);
        chk("err", o_err, q[0].e);
        if (i_ready) begin
          void'(q.pop_front());
          seen = 0;
          consumed = 1;
        end
      end
      if (i_valid && o_ready) begin
        e = model(i_op, i_A, i_B);
        e.due = cyc + e.lat;
        q.push_back(e);
      end
    end
    r2 = r1;
    r1 = i_rst_n;
    consumed_prev = consumed;
  end

  task automatic junk_inputs();
    i_A  = 8'($urandom);
    i_B  = 8'($urandom);
    i_op = 3'($urandom);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    i_op = op; i_A = a; i_B = b; i_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (o_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    junk_inputs();
  endtask

  // While waiting, i_valid is toggled with junk operands: it must be ignored.
  task automatic take(input int stall, input bit lit, input logic [15:0] er,
                      input logic ec, input logic ee, input logic ez);
    int t = 0;
    do begin
      @(posedge clk); #1;
      i_valid = 1'($urandom);
      junk_inputs();
      @(negedge clk);
      t++;
    end while (!o_valid && t < 100);
    if (!o_valid) chk("valid_timeout", o_valid, 1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      i_valid = 1'($urandom);
      junk_inputs();
      @(negedge clk);
    end
    if (lit) begin
      chk("lit_result", o_result, er);
      chk("lit_carry", o_carry, ec);
      chk("lit_err", o_err, ee);
      chk("lit_zero", o_zero, ez);
      chk("lit_ready_low", o_ready, 0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;

    send(3'd0, 8'd200, 8'd100);   take(0, 1, 16'h012C, 1, 0, 0);
    send(3'd1, 8'd5,   8'd9);     take(0, 1, 16'h0004, 1, 0, 0);
    send(3'd6, 8'h33,  8'h33);    take(0, 1, 16'h0001, 0, 0, 0);
    send(3'd6, 8'h40,  8'h3F);    take(1, 1, 16'h0002, 0, 0, 0);
    send(3'd2, 8'd255, 8'd255);   take(5, 1, 16'hFE01, 0, 0, 0);
    send(3'd3, 8'hF0,  8'h3C);    take(0, 1, 16'h0030, 0, 0, 0);
    send(3'd4, 8'hF0,  8'h3C);    take(0, 1, 16'h00FC, 0, 0, 0);
`ifdef ALU_DIV_EN
    // 200 = 7*28 + 4 ; divide by zero returns {A, all ones}
    send(3'd7, 8'd200, 8'd7);     take(0, 1, 16'h041C, 0, 0, 0);
    send(3'd7, 8'd77,  8'd0);     take(0, 1, 16'h4DFF, 0, 1, 0);
`else
    send(3'd7, 8'd200, 8'd7);     take(0, 1, 16'hFFFF, 0, 1, 0);
    send(3'd7, 8'd77,  8'd0);     take(0, 1, 16'hFFFF, 0, 1, 0);
`endif

    // Abort a multiply in its fourth CALC cycle.
    send(3'd2, 8'd123, 8'd45);
    repeat (3) begin @(posedge clk); #1; end
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    repeat (14) begin @(posedge clk); #1; end

    send(3'd5, 8'hAA, 8'hAA);     take(0, 1, 16'h0000, 0, 0, 1);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(op, a, b);
      take($urandom_range(0, 3), 0, 16'h0, 0, 0, 0);
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
